// File: rtl/char_action_sched.sv
// char_action_sched: per-frame action scheduler between raw player inputs
// and the character movement controller. It owns the frame tick, sequences
// the melee attack (IDLE -> WINDUP -> ACTIVE -> RECOVER -> COOLDOWN -> IDLE)
// and gates left/right/jump step commands so movement and attack never
// conflict. All outputs are registered.
// Optional build macro: ATTACK_BUFFER_EN adds a single-entry attack buffer
// that chains an attack edge seen in RECOVER/COOLDOWN straight into WINDUP.
module char_action_sched #(
  parameter int unsigned FRAME_TICKS     = 1_083_333,
  parameter int unsigned WINDUP_FRAMES   = 4,
  parameter int unsigned ACTIVE_FRAMES   = 6,
  parameter int unsigned RECOVER_FRAMES  = 4,
  parameter int unsigned COOLDOWN_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       key_jump,
  input  logic       mouse_left,
  input  logic       on_ground,
  output logic       stepleft,
  output logic       stepright,
  output logic       stepjump,
  output logic       frame_tick,
  output logic [1:0] attack_phase,
  output logic       attack_hit,
  output logic       cooldown_busy
);

  localparam int unsigned TW    = $clog2(FRAME_TICKS);
  localparam int unsigned MAX01 = (WINDUP_FRAMES > ACTIVE_FRAMES) ? WINDUP_FRAMES : ACTIVE_FRAMES;
  localparam int unsigned MAX23 = (RECOVER_FRAMES > COOLDOWN_FRAMES) ? RECOVER_FRAMES : COOLDOWN_FRAMES;
  localparam int unsigned MAXF  = (MAX01 > MAX23) ? MAX01 : MAX23;
  localparam int unsigned FW    = $clog2(MAXF + 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WINDUP   = 3'd1;
  localparam logic [2:0] ST_ACTIVE   = 3'd2;
  localparam logic [2:0] ST_RECOVER  = 3'd3;
  localparam logic [2:0] ST_COOLDOWN = 3'd4;

  // Externally visible phase code; COOLDOWN reports as 0 alongside cooldown_busy.
  function automatic logic [1:0] phase_of(input logic [2:0] st);
    case (st)
      ST_WINDUP:  phase_of = 2'd1;
      ST_ACTIVE:  phase_of = 2'd2;
      ST_RECOVER: phase_of = 2'd3;
      default:    phase_of = 2'd0;
    endcase
  endfunction

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]    state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          pend_q, pend_d;
  logic          mouse_q;
  logic          tick_s, edge_s, cd_expire_s, move_ok_s, jump_ok_s;
  logic          stepleft_q, stepright_q, stepjump_q, frame_tick_q;
  logic [1:0]    phase_q;
  logic          hit_q, busy_q;
`ifdef ATTACK_BUFFER_EN
  logic          buf_q, buf_d;
`endif

  assign tick_s      = (tick_cnt_q == TW'(FRAME_TICKS - 1));
  assign edge_s      = mouse_left & ~mouse_q;
  assign cd_expire_s = (state_q == ST_COOLDOWN) && tick_s && (fcnt_q == '0);

  // Free-running frame counter 0..FRAME_TICKS-1.
  always_comb begin
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Attack FSM: moves only on tick cycles; each timed state lasts N ticks.
  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (tick_s && pend_q) begin
          state_d = ST_WINDUP;
          fcnt_d  = FW'(WINDUP_FRAMES - 1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WINDUP: begin
        if (tick_s && fcnt_q == '0) begin
          state_d = ST_ACTIVE;
          fcnt_d  = FW'(ACTIVE_FRAMES - 1);
        end else if (tick_s) begin
          fcnt_d = fcnt_q - FW'(1);
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      ST_ACTIVE: begin
        if (tick_s && fcnt_q == '0) begin
          state_d = ST_RECOVER;
          fcnt_d  = FW'(RECOVER_FRAMES - 1);
        end else if (tick_s) begin
          fcnt_d = fcnt_q - FW'(1);
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      ST_RECOVER: begin
        if (tick_s && fcnt_q == '0) begin
          state_d = ST_COOLDOWN;
          fcnt_d  = FW'(COOLDOWN_FRAMES - 1);
        end else if (tick_s) begin
          fcnt_d = fcnt_q - FW'(1);
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      ST_COOLDOWN: begin
        if (cd_expire_s) begin
`ifdef ATTACK_BUFFER_EN
          // An edge on the expiry cycle itself counts as buffered.
          if (buf_q || edge_s) begin
            state_d = ST_WINDUP;
            fcnt_d  = FW'(WINDUP_FRAMES - 1);
          end else begin
            state_d = ST_IDLE;
            fcnt_d  = '0;
          end
`else
          state_d = ST_IDLE;
          fcnt_d  = '0;
`endif
        end else if (tick_s) begin
          fcnt_d = fcnt_q - FW'(1);
        end else begin
          fcnt_d = fcnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        fcnt_d  = '0;
      end
    endcase
  end

  // Pending request: set by an edge in IDLE, cleared when IDLE consumes it.
  always_comb begin
    if (state_q == ST_IDLE && tick_s && pend_q) begin
      pend_d = 1'b0;
    end else if (state_q == ST_IDLE && edge_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_q;
    end
  end

`ifdef ATTACK_BUFFER_EN
  // Single-entry buffer for one edge seen in RECOVER/COOLDOWN.
  always_comb begin
    if (cd_expire_s) begin
      buf_d = 1'b0;
    end else if ((state_q == ST_RECOVER || state_q == ST_COOLDOWN) && edge_s) begin
      buf_d = 1'b1;
    end else begin
      buf_d = buf_q;
    end
  end
`endif

  // Movement permissions follow the state the outputs will report.
  always_comb begin
    move_ok_s = (state_d == ST_IDLE) || (state_d == ST_RECOVER) || (state_d == ST_COOLDOWN);
    jump_ok_s = (state_d == ST_IDLE) || (state_d == ST_COOLDOWN);
  end

  // State and registered outputs; reset preloads the mouse edge register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_cnt_q   <= '0;
      state_q      <= ST_IDLE;
      fcnt_q       <= '0;
      pend_q       <= 1'b0;
      mouse_q      <= mouse_left;
      stepleft_q   <= 1'b0;
      stepright_q  <= 1'b0;
      stepjump_q   <= 1'b0;
      frame_tick_q <= 1'b0;
      phase_q      <= 2'd0;
      hit_q        <= 1'b0;
      busy_q       <= 1'b0;
`ifdef ATTACK_BUFFER_EN
      buf_q        <= 1'b0;
`endif
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      state_q      <= state_d;
      fcnt_q       <= fcnt_d;
      pend_q       <= pend_d;
      mouse_q      <= mouse_left;
      stepleft_q   <= key_left & ~key_right & move_ok_s;
      stepright_q  <= key_right & ~key_left & move_ok_s;
      stepjump_q   <= key_jump & on_ground & jump_ok_s;
      frame_tick_q <= tick_s;
      phase_q      <= phase_of(state_d);
      hit_q        <= (state_d == ST_ACTIVE) && (state_q != ST_ACTIVE);
      busy_q       <= (state_d == ST_COOLDOWN);
`ifdef ATTACK_BUFFER_EN
      buf_q        <= buf_d;
`endif
    end
  end

  assign stepleft      = stepleft_q;
  assign stepright     = stepright_q;
  assign stepjump      = stepjump_q;
  assign frame_tick    = frame_tick_q;
  assign attack_phase  = phase_q;
  assign attack_hit    = hit_q;
  assign cooldown_busy = busy_q;

endmodule
